// File: rtl/clock_divider_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clock_divider_pkg;

  // Divider control states; STOPPING keeps counting until the period ends.
  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUNNING  = 2'd1,
    STOPPING = 2'd2
  } div_state_t;

  // Smallest ratio that still gives a high and a low phase.
  localparam int unsigned MIN_DIV_RATIO = 2;

  // Requested ratios of 0 and 1 are meaningless; lift them to the minimum.
  function automatic logic [31:0] clamp_ratio(input logic [31:0] value);
    return (value < MIN_DIV_RATIO) ? MIN_DIV_RATIO : value;
  endfunction

endpackage

// File: rtl/clock_duty_corrector.sv
// Negedge half-cycle retimer for odd division ratios.
// Built only when CLOCK_DIVIDER_DUTY_CORRECTION_EN is defined; in the default
// build this file contributes no module.
`ifdef CLOCK_DIVIDER_DUTY_CORRECTION_EN
module clock_duty_corrector (
  input  logic clk,
  input  logic rst,
  input  logic odd_ratio,
  input  logic clk_pos,
  output logic clk_div
);

  logic clk_neg;

  // Echo the posedge high phase half a cycle later so its falling edge moves out by half a clk.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) clk_neg <= 1'b0;
    else     clk_neg <= clk_pos & odd_ratio;
  end

  assign clk_div = clk_pos | clk_neg;

endmodule
`endif

// File: rtl/programmable_clock_divider.sv
// Runtime-programmable integer clock divider with a source-domain tick strobe.
// Ratio changes and start/stop take effect only at period boundaries.
// Optional feature macro: CLOCK_DIVIDER_DUTY_CORRECTION_EN (50% duty for odd ratios).
module programmable_clock_divider
  import clock_divider_pkg::*;
#(
  parameter int COUNTER_WIDTH = 8,
  parameter int DEFAULT_RATIO = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [COUNTER_WIDTH-1:0] div_value,
  input  logic                     div_load,
  output logic                     clk_div,
  output logic                     tick,
  output logic                     running,
  output logic                     ratio_pending,
  output div_state_t               dbg_state
);

  // Load interface: div_load is a single-cycle strobe with no back-pressure.
  // Every cycle it is high, div_value is accepted; while the divider runs the
  // value waits in pending_ratio (last write wins) until the period wraps.

  div_state_t               state, state_next;
  logic [COUNTER_WIDTH-1:0] cnt;
  logic [COUNTER_WIDTH-1:0] active_ratio;
  logic [COUNTER_WIDTH-1:0] pending_ratio;
  logic [COUNTER_WIDTH-1:0] load_ratio;
  logic [COUNTER_WIDTH:0]   high_limit;
  logic                     active;
  logic                     at_wrap;
  logic                     high_phase;
  logic                     clk_pos, clk_pos_d;
  logic                     tick_d;

  assign load_ratio = COUNTER_WIDTH'(clamp_ratio(32'(div_value)));
  assign active     = (state != STOPPED);
  assign at_wrap    = (cnt == (active_ratio - COUNTER_WIDTH'(1)));

  // The half-ratio is formed one bit wider so R = 2^W-1 cannot overflow.
  // With duty correction the posedge phase is floor(R/2); the retimer adds
  // the missing half cycle for odd R.
`ifdef CLOCK_DIVIDER_DUTY_CORRECTION_EN
  assign high_limit = {1'b0, active_ratio} >> 1;
`else
  assign high_limit = ({1'b0, active_ratio} + {{COUNTER_WIDTH{1'b0}}, 1'b1}) >> 1;
`endif
  assign high_phase = ({1'b0, cnt} < high_limit);

  // Next-state and next-output decode from the current state and count.
  always_comb begin
    state_next = state;
    clk_pos_d  = 1'b0;
    tick_d     = 1'b0;
    case (state)
      STOPPED:  if (enable) state_next = RUNNING;
      RUNNING:  if (!enable) state_next = STOPPING;
      STOPPING: begin
        if (enable)       state_next = RUNNING;
        else if (at_wrap) state_next = STOPPED;
      end
      default:  state_next = STOPPED;
    endcase
    if (active) begin
      clk_pos_d = high_phase;
      tick_d    = (cnt == '0);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= STOPPED;
    else     state <= state_next;
  end

  // Period counter: held at zero while stopped, wraps at R-1 otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt <= '0;
    else if (!active) cnt <= '0;
    else if (at_wrap) cnt <= '0;
    else              cnt <= cnt + COUNTER_WIDTH'(1);
  end

  // Ratio bookkeeping: immediate while stopped, deferred to the wrap edge otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_ratio  <= COUNTER_WIDTH'(DEFAULT_RATIO);
      pending_ratio <= '0;
      ratio_pending <= 1'b0;
    end else if (!active) begin
      if (div_load) active_ratio <= load_ratio;
    end else if (at_wrap) begin
      if (div_load)           active_ratio <= load_ratio;
      else if (ratio_pending) active_ratio <= pending_ratio;
      ratio_pending <= 1'b0;
    end else if (div_load) begin
      pending_ratio <= load_ratio;
      ratio_pending <= 1'b1;
    end
  end

  // Registered divided clock and tick, one cycle behind the count they decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_pos <= 1'b0;
      tick    <= 1'b0;
    end else begin
      clk_pos <= clk_pos_d;
      tick    <= tick_d;
    end
  end

`ifdef CLOCK_DIVIDER_DUTY_CORRECTION_EN
  clock_duty_corrector u_duty (
    .clk       (clk),
    .rst       (rst),
    .odd_ratio (active_ratio[0]),
    .clk_pos   (clk_pos),
    .clk_div   (clk_div)
  );
`else
  assign clk_div = clk_pos;
`endif

  assign running   = active;
  assign dbg_state = state;

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Self-checking bench for programmable_clock_divider (COUNTER_WIDTH=8, DEFAULT_RATIO=2).
module tb_programmable_clock_divider;
  import clock_divider_pkg::*;

  localparam int W = 8;
  localparam int DEF_R = 2;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [W-1:0] div_value;
  logic         div_load;
  logic         clk_div, tick, running, ratio_pending;
  div_state_t   dbg_state;

  always #5 clk = ~clk;

  programmable_clock_divider #(.COUNTER_WIDTH(W), .DEFAULT_RATIO(DEF_R)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .div_value     (div_value),
    .div_load      (div_load),
    .clk_div       (clk_div),
    .tick          (tick),
    .running       (running),
    .ratio_pending (ratio_pending),
    .dbg_state     (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Waveform queue: when a period starts, its R output samples {clk_div,tick}
  // are queued; one sample is emitted per clk. Emptying the queue is the
  // period boundary, where ratio changes and stop decisions are resolved.
  logic [1:0] exp_q[$];
  bit  m_active   = 0;
  bit  m_stopping = 0;
  int  m_ratio    = DEF_R;
  bit  m_pend_v   = 0;
  int  m_pend     = 0;
  logic exp_clk = 0, exp_tick = 0;

  function automatic int clamp(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic void push_period(input int r);
    for (int i = 0; i < r; i++) exp_q.push_back({(i < (r + 1) / 2), (i == 0)});
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [1:0] s;
    bit boundary;
    if (rst) begin
      exp_q.delete();
      m_active = 0; m_stopping = 0; m_ratio = DEF_R; m_pend_v = 0;
      exp_clk = 0; exp_tick = 0;
    end else if (!m_active) begin
      exp_clk = 0; exp_tick = 0;
      if (div_load) m_ratio = clamp(int'(div_value));
      if (enable) begin
        m_active = 1; m_stopping = 0;
        push_period(m_ratio);
      end
    end else begin
      s = exp_q.pop_front();
      exp_clk = s[1]; exp_tick = s[0];
      boundary = (exp_q.size() == 0);
      if (boundary) begin
        if (div_load)      m_ratio = clamp(int'(div_value));
        else if (m_pend_v) m_ratio = m_pend;
        m_pend_v = 0;
        if (m_stopping && !enable) begin
          m_active = 0;
        end else begin
          push_period(m_ratio);
        end
      end else if (div_load) begin
        m_pend = clamp(int'(div_value)); m_pend_v = 1;
      end
      m_stopping = m_active && !enable;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    div_state_t exp_state;
    exp_state = !m_active ? STOPPED : (m_stopping ? STOPPING : RUNNING);
`ifndef CLOCK_DIVIDER_DUTY_CORRECTION_EN
    check("cmp_clk_div", clk_div, exp_clk);
`endif
    check("cmp_tick", tick, exp_tick);
    check("cmp_running", running, m_active);
    check("cmp_ratio_pending", ratio_pending, m_pend_v);
    check("cmp_state", dbg_state, exp_state);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_stopped(input int v);
    div_value = W'(v);
    div_load  = 1'b1;
    step();
    div_load  = 1'b0;
  endtask

  task automatic stop_and_wait();
    int n;
    enable = 1'b0;
    n = 0;
    while (running === 1'b1 && n < 1000) begin
      step();
      n++;
    end
    check("stop_reached", running, 0);
  endtask

`ifdef CLOCK_DIVIDER_DUTY_CORRECTION_EN
  task automatic wait_div_level(input logic level, output bit ok);
    int n;
    n = 0;
    while (clk_div !== level && n < 2000) begin
      #1;
      n++;
    end
    ok = (clk_div === level);
  endtask
`endif

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; enable = 1'b0; div_value = '0; div_load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_clk_div", clk_div, 0);
    check("reset_tick", tick, 0);
    check("reset_running", running, 0);
    check("reset_pending", ratio_pending, 0);

    // R=5 running, then an asynchronous reset in the middle of a high phase.
    load_stopped(5);
    enable = 1'b1;
    step();
    repeat (7) step();
    check("r5_high_before_reset", clk_div, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_clk_div", clk_div, 0);
    check("midrst_tick", tick, 0);
    check("midrst_running", running, 0);
    check("midrst_pending", ratio_pending, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("restart_running", running, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("default_r2_clk", clk_div, (i % 2 == 0));
      check("default_r2_tick", tick, (i % 2 == 0));
    end
    stop_and_wait();

    // R=6: three high, three low, tick on each rise.
    load_stopped(6);
    enable = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      step();
      check("r6_clk", clk_div, (i % 6 < 3));
      check("r6_tick", tick, (i % 6 == 0));
    end
    stop_and_wait();

    // R=4 with a reload to 7 one cycle into the period.
    load_stopped(4);
    enable = 1'b1;
    step();
    step();
    div_value = 8'd7; div_load = 1'b1;
    step();
    div_load = 1'b0;
    check("r4to7_pending_a", ratio_pending, 1);
    step();
    check("r4to7_pending_b", ratio_pending, 1);
    step();
    check("r4to7_pending_clear", ratio_pending, 0);
    check("r4to7_last_low", clk_div, 0);
    for (int i = 0; i < 14; i++) begin
      step();
      check("r7_clk", clk_div, (i % 7 < 4));
      check("r7_tick", tick, (i % 7 == 0));
    end

    // Two loads before the boundary: the second one (5) wins.
    step();
    div_value = 8'd3; div_load = 1'b1;
    step();
    div_value = 8'd5;
    step();
    div_load = 1'b0;
    check("last_wins_pending", ratio_pending, 1);
    repeat (4) step();
    for (int i = 0; i < 10; i++) begin
      step();
      check("r5_clk", clk_div, (i % 5 < 3));
    end

    // Load on the wrap cycle itself: applies at once, pending never rises.
    repeat (4) step();
    div_value = 8'd2; div_load = 1'b1;
    step();
    div_load = 1'b0;
    check("wrap_load_no_pending", ratio_pending, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("wrap_load_r2_clk", clk_div, (i % 2 == 0));
    end
    stop_and_wait();

    // R=3, enable dropped on the first count: period completes then stops.
    load_stopped(3);
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("r3stop_clk", clk_div, (i < 2));
      check("r3stop_tick", tick, (i == 0));
      check("r3stop_running", running, (i < 2));
    end
    for (int i = 0; i < 4; i++) begin
      step();
      check("r3stop_hold_clk", clk_div, 0);
      check("r3stop_hold_running", running, 0);
    end

    // R=4: enable drops then returns before the boundary; waveform is seamless.
    load_stopped(4);
    enable = 1'b1;
    step();
    enable = 1'b0;
    step();
    step();
    enable = 1'b1;
    for (int j = 2; j < 14; j++) begin
      step();
      check("r4_resume_clk", clk_div, (j % 4 < 2));
    end
    // enable falls together with a load of 6; the stop edge activates it.
    enable = 1'b0; div_value = 8'd6; div_load = 1'b1;
    step();
    div_load = 1'b0;
    step();
    step();
    check("stop_with_load_running", running, 0);
    enable = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      check("stop_load_r6_clk", clk_div, (i < 3));
    end
    stop_and_wait();

    // Clamped ratios 0 and 1 behave as 2.
    for (int v = 0; v < 2; v++) begin
      load_stopped(v);
      enable = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
        step();
        check("clamp_clk", clk_div, (i % 2 == 0));
      end
      stop_and_wait();
    end

    // Maximum ratio 255: 128 high, 127 low.
    load_stopped(255);
    enable = 1'b1;
    step();
    for (int i = 0; i < 255; i++) begin
      step();
      check("r255_clk", clk_div, (i < 128));
      check("r255_tick", tick, (i == 0));
    end
    step();
    check("r255_next_tick", tick, 1);
    stop_and_wait();

`ifdef CLOCK_DIVIDER_DUTY_CORRECTION_EN
    begin
      bit ok;
      realtime t_rise, t_fall, t_rise2;
      load_stopped(5);
      enable = 1'b1;
      wait_div_level(1'b1, ok);
      check("duty_rise_seen", ok, 1);
      t_rise = $realtime;
      wait_div_level(1'b0, ok);
      check("duty_fall_seen", ok, 1);
      t_fall = $realtime;
      wait_div_level(1'b1, ok);
      check("duty_rise2_seen", ok, 1);
      t_rise2 = $realtime;
      check("duty_high_time", int'(t_fall - t_rise), 25);
      check("duty_low_time", int'(t_rise2 - t_fall), 25);
      step();
      stop_and_wait();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
